// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if.sv - write/read handshake bundle for the elastic buffer
interface gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] I;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] Z;
  logic             Z_VALID;
  logic             Z_READY;
  logic [CW-1:0]    COUNT;

  // Producer/consumer side: drives write data and read acceptance.
  modport master (
    output I, I_VALID, Z_READY,
    input  I_READY, Z, Z_VALID, COUNT
  );

  // Buffer side.
  modport slave (
    input  I, I_VALID, Z_READY,
    output I_READY, Z, Z_VALID, COUNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv - WIDTH x DEPTH elastic buffer; optional bypass via GF180MCU_FD_SC_MCU7T5V0_BUF_FIFO_BYPASS_EN
module gf180mcu_fd_sc_mcu7t5v0__buf_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if.slave bus
);

  // Pointer width covers 0..DEPTH-1; DEPTH need not be a power of two.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

  // Supply pins exist only for library pin compatibility.
  wire w_unused_vdd = VDD;
  wire w_unused_vss = VSS;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_ready;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LP_LAST) ? '0 : p + PW'(1);
  endfunction

  // Status flags and handshake qualification, all derived from registered state.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == LP_FULL);
    // Held low during reset so nothing is offered as accepted while RN=0.
    w_ready = RN & ~w_full;
`ifdef GF180MCU_FD_SC_MCU7T5V0_BUF_FIFO_BYPASS_EN
    // Empty buffer with both sides ready: hand the word straight through.
    w_bypass = RN & w_empty & bus.I_VALID & bus.Z_READY;
`else
    w_bypass = 1'b0;
`endif
    // A bypassed word is consumed downstream and never stored.
    w_push = bus.I_VALID & w_ready & ~w_bypass;
    w_pop  = ~w_empty & bus.Z_READY;
  end

  // Head word is forced to zero when nothing valid is held.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign bus.I_READY = w_ready;
  assign bus.Z_VALID = ~w_empty | w_bypass;
  assign bus.Z       = w_bypass ? bus.I : w_head;
  assign bus.COUNT   = r_count;

  // Pointer and occupancy tracking; reset drops all contents at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is written only on an accepted push, so X on I cannot leak in.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.I;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv - scoreboard bench for DEPTH=4 and DEPTH=3 buffers
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo;

`ifdef GF180MCU_FD_SC_MCU7T5V0_BUF_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  wire  VDD = 1'b1;
  wire  VSS = 1'b0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  gf180mcu_fd_sc_mcu7t5v0__buf_fifo_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  gf180mcu_fd_sc_mcu7t5v0__buf_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .CLK(CLK), .RN(RN), .VDD(VDD), .VSS(VSS), .bus(bus4)
  );
  gf180mcu_fd_sc_mcu7t5v0__buf_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(CLK), .RN(RN), .VDD(VDD), .VSS(VSS), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mq [2][$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus4.I_VALID = v; bus4.I = d; bus4.Z_READY = r;
    bus3.I_VALID = v; bus3.I = d; bus3.Z_READY = r;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares both buffers to queue models on every falling edge,
  // then advances the models by what the next rising edge will do.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int dep, cnt, sz;
      logic zv, ir, iv, zr, byp, popd, pushd;
      logic [7:0] zd, id;
      string tag;
      if (k == 0) begin
        dep = 4; cnt = int'(bus4.COUNT); zv = bus4.Z_VALID; ir = bus4.I_READY;
        zd = bus4.Z; iv = bus4.I_VALID; id = bus4.I; zr = bus4.Z_READY; tag = "d4";
      end else begin
        dep = 3; cnt = int'(bus3.COUNT); zv = bus3.Z_VALID; ir = bus3.I_READY;
        zd = bus3.Z; iv = bus3.I_VALID; id = bus3.I; zr = bus3.Z_READY; tag = "d3";
      end
      if (!RN) begin
        mq[k].delete();
        chk({tag, "_rst_count"}, cnt, 0);
        chk({tag, "_rst_zvalid"}, int'(zv), 0);
        chk({tag, "_rst_z"}, int'(zd), 0);
        chk({tag, "_rst_iready"}, int'(ir), 0);
      end else begin
        sz  = mq[k].size();
        byp = BYP && (sz == 0) && iv && zr;
        chk({tag, "_count"}, cnt, sz);
        chk({tag, "_iready"}, int'(ir), int'(sz != dep));
        chk({tag, "_zvalid"}, int'(zv), int'((sz != 0) || byp));
        if (byp)          chk({tag, "_z_bypass"}, int'(zd), int'(id));
        else if (sz != 0) chk({tag, "_z_head"}, int'(zd), int'(mq[k][0]));
        else              chk({tag, "_z_idle"}, int'(zd), 0);
        popd  = (sz != 0) && zr;
        pushd = iv && (sz != dep) && !byp;
        if (popd)  void'(mq[k].pop_front());
        if (pushd) mq[k].push_back(id);
      end
    end
  end

  initial begin
    // Reset held across three edges with a write request pending.
    drive(1'b1, 8'hFF, 1'b0);
    RN = 1'b0;
    repeat (3) step();
    chk("rst_count", int'(bus4.COUNT), 0);
    chk("rst_zvalid", int'(bus4.Z_VALID), 0);
    chk("rst_z", int'(bus4.Z), 0);
    chk("rst_iready", int'(bus4.I_READY), 0);
    RN = 1'b1;
    #1;
    chk("rel_iready", int'(bus4.I_READY), 1);

    // Fill to capacity, offer a fifth word, then drain.
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h33, 1'b0); step();
    drive(1'b1, 8'h44, 1'b0); step();
    chk("fill_count", int'(bus4.COUNT), 4);
    chk("fill_iready", int'(bus4.I_READY), 0);
    chk("fill_head", int'(bus4.Z), 8'h11);
    drive(1'b1, 8'h55, 1'b0); step();
    chk("full_hold_count", int'(bus4.COUNT), 4);
    drive(1'b0, 8'h00, 1'b1);
    chk("drain_z0", int'(bus4.Z), 8'h11); step();
    chk("drain_z1", int'(bus4.Z), 8'h22); step();
    chk("drain_z2", int'(bus4.Z), 8'h33); step();
    chk("drain_z3", int'(bus4.Z), 8'h44); step();
    chk("drain_count", int'(bus4.COUNT), 0);
    chk("drain_zvalid", int'(bus4.Z_VALID), 0);

    // Steady occupancy of two with push+pop each edge, across pointer wrap.
    drive(1'b1, 8'hE1, 1'b0); step();
    drive(1'b1, 8'hE2, 1'b0); step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      step();
      chk("wrap_count4", int'(bus4.COUNT), 2);
      chk("wrap_count3", int'(bus3.COUNT), 2);
    end
    chk("wrap_head4", int'(bus4.Z), 8'h09);
    drive(1'b0, 8'h00, 1'b1); step(); step();

    // Full with pop: the push waits one edge.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0);
      step();
    end
    chk("fp_full", int'(bus4.COUNT), 4);
    drive(1'b1, 8'h66, 1'b1); step();
    chk("fp_pop_only", int'(bus4.COUNT), 3);
    chk("fp_head", int'(bus4.Z), 8'h61);
    step();
    chk("fp_push_pop", int'(bus4.COUNT), 3);

    // Asynchronous reset between edges at COUNT=3.
    drive(1'b0, 8'h00, 1'b0);
    @(posedge CLK);
    #3;
    RN = 1'b0;
    #1;
    chk("arst_count", int'(bus4.COUNT), 0);
    chk("arst_zvalid", int'(bus4.Z_VALID), 0);
    @(posedge CLK);
    #1;
    RN = 1'b1;
    drive(1'b1, 8'hA5, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("arst_zvalid_after", int'(bus4.Z_VALID), 1);
    chk("arst_z_after", int'(bus4.Z), 8'hA5);
    chk("arst_count_after", int'(bus4.COUNT), 1);
    drive(1'b0, 8'h00, 1'b1); step();

    // Empty buffer with both sides ready: bypass or one-cycle latency.
    drive(1'b1, 8'h5A, 1'b1);
    #1;
    chk("lat_zvalid", int'(bus4.Z_VALID), int'(BYP));
    chk("lat_z", int'(bus4.Z), BYP ? 8'h5A : 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("lat_count", int'(bus4.COUNT), BYP ? 0 : 1);
    chk("lat_zvalid_post", int'(bus4.Z_VALID), BYP ? 0 : 1);
    drive(1'b0, 8'h00, 1'b1); step();

    // Randomised traffic, checked entirely by the monitor.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
